// File: rtl/odd_issue_scheduler.sv
// In-order odd-pipe issue stage: instruction FIFO, RAW scoreboard and single writeback-port reservation ring.
// Define ODD_SCHED_FWD_EN to model the final-execute-stage bypass (dependents may issue one cycle earlier).

module odd_issue_scheduler #(
    parameter int DEPTH    = 4,
    parameter int PERM_LAT = 4,
    parameter int LS_LAT   = 6,
    parameter int BR_LAT   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_unit,
    input  logic [6:0]  in_rt,
    input  logic [6:0]  in_ra,
    input  logic [6:0]  in_rb,
    input  logic [6:0]  in_rc,
    input  logic [2:0]  in_uses,
    input  logic        in_writes,
    input  logic        flush,
    output logic        issue_valid,
    output logic [1:0]  issue_unit,
    output logic [6:0]  issue_rt,
    output logic [6:0]  issue_ra,
    output logic [6:0]  issue_rb,
    output logic [6:0]  issue_rc,
    output logic        wb_valid,
    output logic [6:0]  wb_rt,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        UNIT_PERM = 2'd0,
        UNIT_LS   = 2'd1,
        UNIT_BR   = 2'd2,
        UNIT_NOP  = 2'd3
    } unit_e;

    typedef struct packed {
        unit_e      unit;
        logic [6:0] rt;
        logic [6:0] ra;
        logic [6:0] rb;
        logic [6:0] rc;
        logic [2:0] uses;
        logic       writes;
    } entry_t;

    localparam int AW = $clog2(DEPTH);
    localparam int RW = (LS_LAT > 1) ? $clog2(LS_LAT) : 1;
    localparam int LW = ($clog2(LS_LAT + 1) < 2) ? 2 : $clog2(LS_LAT + 1);
    localparam int SW = RW + LW;

    entry_t        fifo_mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    entry_t        head;
    entry_t        push_entry;

    logic [LW-1:0] lat;
    logic [LW-1:0] sb_load;
    logic          head_nop;
    logic          head_writes;
    logic          hazard;
    logic          conflict;
    logic          issue_write;
    logic          bypass;

    logic [LW-1:0] sb_cnt [LS_LAT];
    logic [6:0]    sb_rt [LS_LAT];
    logic          wb_res [LS_LAT];
    logic [6:0]    wb_res_rt [LS_LAT];
    logic [RW-1:0] slot_ptr;
    logic [RW-1:0] rd_slot;
    logic [RW-1:0] tgt_slot;
    logic [SW-1:0] tgt_sum;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready = !full && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = issue_valid;
    assign head     = fifo_mem[rd_ptr[AW-1:0]];

    always_comb begin
        push_entry        = '0;
        push_entry.unit   = unit_e'(in_unit);
        push_entry.rt     = in_rt;
        push_entry.ra     = in_ra;
        push_entry.rb     = in_rb;
        push_entry.rc     = in_rc;
        push_entry.uses   = in_uses;
        push_entry.writes = in_writes;
    end

    always_comb begin
        lat = '0;
        case (head.unit)
            UNIT_PERM: lat = LW'(PERM_LAT);
            UNIT_LS:   lat = LW'(LS_LAT);
            UNIT_BR:   lat = LW'(BR_LAT);
            default:   lat = '0;
        endcase
    end

    assign head_nop    = (head.unit == UNIT_NOP);
    assign head_writes = head.writes && !head_nop;

`ifdef ODD_SCHED_FWD_EN
    assign sb_load = (lat >= LW'(2)) ? lat - LW'(2) : '0;
`else
    assign sb_load = (lat >= LW'(1)) ? lat - LW'(1) : '0;
`endif

    // slot_ptr names the current cycle modulo LS_LAT; rd_slot is next cycle's writeback slot.
    assign rd_slot  = (slot_ptr == RW'(LS_LAT - 1)) ? '0 : slot_ptr + RW'(1);
    assign tgt_sum  = SW'(slot_ptr) + SW'(lat);
    assign tgt_slot = (tgt_sum >= SW'(LS_LAT)) ? RW'(tgt_sum - SW'(LS_LAT)) : RW'(tgt_sum);

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < LS_LAT; i++) begin
            if (sb_cnt[i] != '0) begin
                if ((head.uses[2] && head.ra == sb_rt[i]) ||
                    (head.uses[1] && head.rb == sb_rt[i]) ||
                    (head.uses[0] && head.rc == sb_rt[i])) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    assign conflict    = head_writes && wb_res[tgt_slot];
    assign issue_valid = !empty && !flush && (head_nop || (!hazard && !conflict));
    assign issue_write = issue_valid && head_writes;
    assign bypass      = issue_write && (tgt_slot == rd_slot);

    assign issue_unit = head.unit;
    assign issue_rt   = head.rt;
    assign issue_ra   = head.ra;
    assign issue_rb   = head.rb;
    assign issue_rc   = head.rc;

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= push_entry;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // A scoreboard entry is reused every LS_LAT cycles, by which time its counter has drained.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_ptr <= '0;
            wb_valid <= 1'b0;
            wb_rt    <= '0;
            for (int i = 0; i < LS_LAT; i++) begin
                sb_cnt[i]    <= '0;
                sb_rt[i]     <= '0;
                wb_res[i]    <= 1'b0;
                wb_res_rt[i] <= '0;
            end
        end else begin
            slot_ptr <= rd_slot;
            wb_valid <= wb_res[rd_slot] || bypass;
            wb_rt    <= bypass ? head.rt : wb_res_rt[rd_slot];
            for (int i = 0; i < LS_LAT; i++) begin
                if (issue_write && slot_ptr == RW'(i)) begin
                    sb_cnt[i] <= sb_load;
                    sb_rt[i]  <= head.rt;
                end else if (sb_cnt[i] != '0) begin
                    sb_cnt[i] <= sb_cnt[i] - LW'(1);
                end
                if (rd_slot == RW'(i)) begin
                    wb_res[i] <= 1'b0;
                end
                if (issue_write && !bypass && tgt_slot == RW'(i)) begin
                    wb_res[i]    <= 1'b1;
                    wb_res_rt[i] <= head.rt;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (!empty && !flush && !issue_valid && stall_count != 16'hFFFF) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_odd_issue_scheduler.sv
// Scoreboard bench for odd_issue_scheduler: directed pushes queue expected issue/writeback events,
// and a negedge monitor pops and compares them cycle-accurately.

module tb_odd_issue_scheduler;

    localparam int PERM_LAT = 4;
    localparam int LS_LAT   = 6;
    localparam int BR_LAT   = 1;
`ifdef ODD_SCHED_FWD_EN
    localparam int FWD = 1;
`else
    localparam int FWD = 0;
`endif
    localparam int RAW_PERM = PERM_LAT - FWD;
    localparam int RAW_LS   = LS_LAT - FWD;

    localparam logic [1:0] U_PERM = 2'd0;
    localparam logic [1:0] U_LS   = 2'd1;
    localparam logic [1:0] U_BR   = 2'd2;
    localparam logic [1:0] U_NOP  = 2'd3;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_unit;
    logic [6:0]  in_rt, in_ra, in_rb, in_rc;
    logic [2:0]  in_uses;
    logic        in_writes;
    logic        flush;
    logic        issue_valid;
    logic [1:0]  issue_unit;
    logic [6:0]  issue_rt, issue_ra, issue_rb, issue_rc;
    logic        wb_valid;
    logic [6:0]  wb_rt;
    logic [15:0] stall_count;

    typedef struct {
        int         cycle;
        logic [1:0] unit;
        logic [6:0] rt;
        logic [6:0] ra;
    } iss_t;

    typedef struct {
        int         cycle;
        logic [6:0] rt;
    } wb_t;

    iss_t exp_iss[$];
    wb_t  exp_wb[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   p;
    int   b;

    odd_issue_scheduler #(
        .DEPTH(4), .PERM_LAT(PERM_LAT), .LS_LAT(LS_LAT), .BR_LAT(BR_LAT)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_unit(in_unit),
        .in_rt(in_rt), .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc),
        .in_uses(in_uses), .in_writes(in_writes), .flush(flush),
        .issue_valid(issue_valid), .issue_unit(issue_unit),
        .issue_rt(issue_rt), .issue_ra(issue_ra), .issue_rb(issue_rb), .issue_rc(issue_rc),
        .wb_valid(wb_valid), .wb_rt(wb_rt), .stall_count(stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    endtask

    task expIssue(input int c, input logic [1:0] unit, input logic [6:0] rt, input logic [6:0] ra);
        iss_t e;
        e.cycle = c; e.unit = unit; e.rt = rt; e.ra = ra;
        exp_iss.push_back(e);
    endtask

    task expWb(input int c, input logic [6:0] rt);
        wb_t w;
        w.cycle = c; w.rt = rt;
        exp_wb.push_back(w);
    endtask

    // Drives one instruction for exactly one cycle; caller sits just after a rising edge.
    task applyStimulus(input logic [1:0] unit, input logic [6:0] rt, input logic [6:0] ra,
                       input logic [6:0] rb, input logic [6:0] rc, input logic [2:0] uses,
                       input logic writes);
        in_valid = 1'b1; in_unit = unit; in_rt = rt; in_ra = ra; in_rb = rb; in_rc = rc;
        in_uses = uses; in_writes = writes;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    task doReset();
        @(posedge clock); #1;
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    task drainCheck(input string name);
        checkOutput({name, "_issue_drained"}, 16'(exp_iss.size()), 16'd0);
        checkOutput({name, "_wb_drained"}, 16'(exp_wb.size()), 16'd0);
        exp_iss.delete();
        exp_wb.delete();
    endtask

    always @(negedge clock) begin
        iss_t e;
        wb_t  w;
        if (reset) begin
            if (issue_valid) begin
                checks++;
                if (exp_iss.size() == 0) begin
                    $display("[TB] FAIL issue_unexpected: got unit %0d rt %0d at cycle %0d, expected no issue",
                             issue_unit, issue_rt, cyc);
                end else begin
                    e = exp_iss.pop_front();
                    if (cyc == e.cycle && issue_unit === e.unit && issue_rt === e.rt && issue_ra === e.ra)
                        passes++;
                    else
                        $display("[TB] FAIL issue_event: got cycle %0d unit %0d rt %0d ra %0d, expected cycle %0d unit %0d rt %0d ra %0d",
                                 cyc, issue_unit, issue_rt, issue_ra, e.cycle, e.unit, e.rt, e.ra);
                end
            end
            if (wb_valid) begin
                checks++;
                if (exp_wb.size() == 0) begin
                    $display("[TB] FAIL wb_unexpected: got rt %0d at cycle %0d, expected no writeback", wb_rt, cyc);
                end else begin
                    w = exp_wb.pop_front();
                    if (cyc == w.cycle && wb_rt === w.rt)
                        passes++;
                    else
                        $display("[TB] FAIL wb_event: got cycle %0d rt %0d, expected cycle %0d rt %0d",
                                 cyc, wb_rt, w.cycle, w.rt);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0;
        in_unit = '0; in_rt = '0; in_ra = '0; in_rb = '0; in_rc = '0; in_uses = '0; in_writes = 1'b0;

        // Reset state
        doReset();
        @(negedge clock);
        checkOutput("rst_in_ready", 16'(in_ready), 16'd1);
        checkOutput("rst_issue_valid", 16'(issue_valid), 16'd0);
        checkOutput("rst_wb_valid", 16'(wb_valid), 16'd0);
        checkOutput("rst_stall_count", stall_count, 16'd0);
        @(posedge clock); #1;

        // Reset mid-operation wipes the queue and the pending LS writeback
        p = cyc;
        expIssue(p + 1, U_LS, 7'd50, 7'd0);
        applyStimulus(U_LS, 7'd50, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1);
        applyStimulus(U_PERM, 7'd51, 7'd50, 7'd0, 7'd0, 3'b100, 1'b1);
        applyStimulus(U_NOP, 7'd52, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0);
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midrst_in_ready", 16'(in_ready), 16'd1);
        checkOutput("midrst_issue_valid", 16'(issue_valid), 16'd0);
        checkOutput("midrst_wb_valid", 16'(wb_valid), 16'd0);
        checkOutput("midrst_stall_count", stall_count, 16'd0);
        @(posedge clock); #1;
        idle(10);
        drainCheck("midrst");

        // RAW on permute, then branch (L=1) with an rb dependent issuing back-to-back
        doReset();
        p = cyc;
        expIssue(p + 1, U_PERM, 7'd10, 7'd0);
        expWb(p + 1 + PERM_LAT, 7'd10);
        applyStimulus(U_PERM, 7'd10, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1);
        expIssue(p + 1 + RAW_PERM, U_PERM, 7'd11, 7'd10);
        expWb(p + 1 + RAW_PERM + PERM_LAT, 7'd11);
        applyStimulus(U_PERM, 7'd11, 7'd10, 7'd0, 7'd0, 3'b100, 1'b1);
        idle(12);
        b = cyc;
        expIssue(b + 1, U_BR, 7'd12, 7'd0);
        expWb(b + 2, 7'd12);
        applyStimulus(U_BR, 7'd12, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1);
        expIssue(b + 2, U_PERM, 7'd13, 7'd0);
        expWb(b + 6, 7'd13);
        applyStimulus(U_PERM, 7'd13, 7'd0, 7'd12, 7'd0, 3'b010, 1'b1);
        idle(10);
        @(negedge clock);
        checkOutput("raw_stall_count", stall_count, 16'(RAW_PERM - 1));
        @(posedge clock); #1;
        drainCheck("raw");

        // Writeback-port conflict holds the permute by one cycle
        doReset();
        p = cyc;
        expIssue(p + 1, U_LS, 7'd5, 7'd0);
        expWb(p + 7, 7'd5);
        applyStimulus(U_LS, 7'd5, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1);
        idle(1);
        expIssue(p + 4, U_PERM, 7'd6, 7'd0);
        expWb(p + 8, 7'd6);
        applyStimulus(U_PERM, 7'd6, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1);
        idle(10);
        @(negedge clock);
        checkOutput("wbc_stall_count", stall_count, 16'd1);
        @(posedge clock); #1;
        drainCheck("wbc");

        // FIFO full behind a hazard; nops carrying in_writes=1 must not write back
        doReset();
        p = cyc;
        expIssue(p + 1, U_LS, 7'd30, 7'd0);
        expWb(p + 7, 7'd30);
        applyStimulus(U_LS, 7'd30, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1);
        expIssue(p + 1 + RAW_LS, U_PERM, 7'd31, 7'd30);
        expWb(p + 1 + RAW_LS + PERM_LAT, 7'd31);
        applyStimulus(U_PERM, 7'd31, 7'd30, 7'd0, 7'd0, 3'b100, 1'b1);
        for (int k = 0; k < 3; k++) begin
            expIssue(p + 2 + RAW_LS + k, U_NOP, 7'(32 + k), 7'd0);
            applyStimulus(U_NOP, 7'(32 + k), 7'd0, 7'd0, 7'd0, 3'b000, 1'b1);
        end
        in_valid = 1'b1; in_unit = U_NOP; in_rt = 7'd35; in_ra = '0; in_uses = '0; in_writes = 1'b0;
        @(negedge clock);
        checkOutput("full_ready_first", 16'(in_ready), 16'd0);
        @(posedge clock); #1;
        @(negedge clock);
        checkOutput("full_ready_second", 16'(in_ready), 16'd0);
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        checkOutput("full_ready_after_pop", 16'(in_ready), 16'(FWD));
        @(posedge clock); #1;
        @(negedge clock);
        checkOutput("full_ready_recovered", 16'(in_ready), 16'd1);
        @(posedge clock); #1;
        idle(12);
        @(negedge clock);
        checkOutput("full_stall_count", stall_count, 16'(RAW_LS - 1));
        @(posedge clock); #1;
        drainCheck("full");

        // Flush empties the queue but in-flight LS writeback completes
        doReset();
        p = cyc;
        expIssue(p + 1, U_LS, 7'd20, 7'd0);
        expWb(p + 7, 7'd20);
        applyStimulus(U_LS, 7'd20, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1);
        applyStimulus(U_PERM, 7'd21, 7'd20, 7'd0, 7'd0, 3'b100, 1'b1);
        applyStimulus(U_NOP, 7'd22, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0);
        flush = 1'b1;
        in_valid = 1'b1; in_unit = U_NOP; in_rt = 7'd23; in_uses = '0; in_writes = 1'b0;
        @(negedge clock);
        checkOutput("flush_in_ready", 16'(in_ready), 16'd0);
        checkOutput("flush_issue_valid", 16'(issue_valid), 16'd0);
        @(posedge clock); #1;
        flush = 1'b0; in_valid = 1'b0;
        idle(1);
        expIssue(p + 6, U_NOP, 7'd24, 7'd0);
        applyStimulus(U_NOP, 7'd24, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0);
        applyStimulus(U_NOP, 7'd25, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0);
        flush = 1'b1;
        @(negedge clock);
        checkOutput("flush_nop_head", 16'(issue_valid), 16'd0);
        @(posedge clock); #1;
        flush = 1'b0;
        idle(10);
        @(negedge clock);
        checkOutput("flush_stall_count", stall_count, 16'd1);
        @(posedge clock); #1;
        drainCheck("flush");

        // Saturation from a preloaded count near the top
        doReset();
        force dut.stall_count = 16'hFFFD;
        @(posedge clock); #1;
        release dut.stall_count;
        p = cyc;
        expIssue(p + 1, U_LS, 7'd40, 7'd0);
        expWb(p + 7, 7'd40);
        applyStimulus(U_LS, 7'd40, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1);
        expIssue(p + 1 + RAW_LS, U_PERM, 7'd41, 7'd40);
        expWb(p + 1 + RAW_LS + PERM_LAT, 7'd41);
        applyStimulus(U_PERM, 7'd41, 7'd40, 7'd0, 7'd0, 3'b100, 1'b1);
        idle(12);
        @(negedge clock);
        checkOutput("sat_stall_count", stall_count, 16'hFFFF);
        @(posedge clock); #1;
        drainCheck("sat");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
